// File: rtl/blink_sequencer.sv
// blink_sequencer: turns single-cycle trigger pulses into fixed-length LED blinks, queueing overlaps
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   trigger  : single-cycle blink request
//   led      : registered LED drive
//   busy     : high while a blink (ON or OFF phase) is in progress
//   pending  : registered count of queued requests
//   overflow : registered one-cycle pulse when a request is dropped
module blink_sequencer #(
    parameter int ON_CYCLES   = 16,
    parameter int OFF_CYCLES  = 16,
    parameter int MAX_PENDING = 7
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               trigger,
    output logic                               led,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               overflow
);
    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW   = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PMAX     = PW'(MAX_PENDING);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          led_q, ovf_q, ovf_d;
    logic          on_done, off_done, dec, take, inc, drop;

    always_comb begin
        on_done  = state_q == S_ON  && cnt_q == ON_LAST;
        off_done = state_q == S_OFF && cnt_q == OFF_LAST;
        // At the end of OFF a queued request is replayed first; a live trigger is only
        // consumed directly when the queue is empty.
        dec      = off_done && pend_q != '0;
        take     = off_done && pend_q == '0 && trigger;
        inc      = trigger && state_q != S_IDLE && !take;
        // A full queue still accepts a trigger when a slot frees in the same cycle.
        drop     = inc && pend_q == PMAX && !dec;
        state_d  = (state_q == S_IDLE && trigger) ? S_ON :
                   on_done                        ? S_OFF :
                   off_done                       ? ((dec || take) ? S_ON : S_IDLE) :
                                                    state_q;
        cnt_d    = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
        pend_d   = pend_q + PW'(inc && !drop) - PW'(dec);
        ovf_d    = drop;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            led_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            led_q   <= state_d == S_ON;
            ovf_q   <= ovf_d;
        end
    end

    assign led      = led_q;
    assign busy     = state_q != S_IDLE;
    assign pending  = pend_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: scoreboard bench driving three parameterisations with a shared trigger
module tb_blink_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       trigger;
    logic       led_w[3];
    logic       busy_w[3];
    logic       ovf_w[3];
    logic [2:0] pend0, pend2;
    logic [1:0] pend1;

    always #5 clk = ~clk;

    blink_sequencer #(.ON_CYCLES(4), .OFF_CYCLES(3), .MAX_PENDING(7)) d0 (
        .clock(clk), .reset_n(rst_n), .trigger(trigger),
        .led(led_w[0]), .busy(busy_w[0]), .pending(pend0), .overflow(ovf_w[0]));
    blink_sequencer #(.ON_CYCLES(4), .OFF_CYCLES(3), .MAX_PENDING(2)) d1 (
        .clock(clk), .reset_n(rst_n), .trigger(trigger),
        .led(led_w[1]), .busy(busy_w[1]), .pending(pend1), .overflow(ovf_w[1]));
    blink_sequencer #(.ON_CYCLES(1), .OFF_CYCLES(1), .MAX_PENDING(7)) d2 (
        .clock(clk), .reset_n(rst_n), .trigger(trigger),
        .led(led_w[2]), .busy(busy_w[2]), .pending(pend2), .overflow(ovf_w[2]));

    typedef struct {
        int led;
        int busy;
        int pend;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   p_on[3]  = '{4, 4, 1};
    int   p_off[3] = '{3, 3, 1};
    int   p_max[3] = '{7, 2, 7};
    int   m_st[3];
    int   m_rem[3];
    int   m_pend[3];
    int   m_ovf[3];
    int   blinks[3];
    int   ovfs[3];
    logic led_prev[3];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic int obs_pend(input int i);
        return (i == 0) ? int'(pend0) : (i == 1) ? int'(pend1) : int'(pend2);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference: state 0=idle 1=on 2=off, m_rem counts cycles left in the current phase.
    task automatic model_step(input int i, input bit t);
        m_ovf[i] = 0;
        if (m_st[i] == 0) begin
            if (t) begin
                m_st[i]  = 1;
                m_rem[i] = p_on[i];
            end
        end else begin
            m_rem[i]--;
            if (m_st[i] == 2 && m_rem[i] == 0) begin
                if (m_pend[i] > 0) begin
                    m_st[i]  = 1;
                    m_rem[i] = p_on[i];
                    if (!t) m_pend[i]--;
                end else if (t) begin
                    m_st[i]  = 1;
                    m_rem[i] = p_on[i];
                end else begin
                    m_st[i] = 0;
                end
            end else begin
                if (t) begin
                    if (m_pend[i] < p_max[i]) m_pend[i]++;
                    else m_ovf[i] = 1;
                end
                if (m_st[i] == 1 && m_rem[i] == 0) begin
                    m_st[i]  = 2;
                    m_rem[i] = p_off[i];
                end
            end
        end
    endtask

    task automatic step(input bit t);
        exp_t e;
        trigger = t;
        for (int i = 0; i < 3; i++) begin
            model_step(i, t);
            e.led  = (m_st[i] == 1) ? 1 : 0;
            e.busy = (m_st[i] != 0) ? 1 : 0;
            e.pend = m_pend[i];
            e.ovf  = m_ovf[i];
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            check($sformatf("led%0d", i), int'(led_w[i]), e.led);
            check($sformatf("busy%0d", i), int'(busy_w[i]), e.busy);
            check($sformatf("pend%0d", i), obs_pend(i), e.pend);
            check($sformatf("ovf%0d", i), int'(ovf_w[i]), e.ovf);
            if (led_w[i] && !led_prev[i]) blinks[i]++;
            if (ovf_w[i]) ovfs[i]++;
            led_prev[i] = led_w[i];
        end
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic clr;
        for (int i = 0; i < 3; i++) begin
            blinks[i] = 0;
            ovfs[i]   = 0;
        end
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without waiting for a clock edge.
    task automatic do_reset;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_led%0d", i), int'(led_w[i]), 0);
            check($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
            check($sformatf("rst_pend%0d", i), obs_pend(i), 0);
            check($sformatf("rst_ovf%0d", i), int'(ovf_w[i]), 0);
            m_st[i]     = 0;
            m_rem[i]    = 0;
            m_pend[i]   = 0;
            m_ovf[i]    = 0;
            led_prev[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b1;
        trigger = 1'b0;
        @(negedge clk);
        do_reset();

        clr();
        step(1'b1);
        drain(40);
        check("t1_blinks", blinks[0], 1);

        clr();
        repeat (3) step(1'b1);
        drain(40);
        check("t2_blinks", blinks[0], 3);

        clr();
        repeat (5) step(1'b1);
        drain(60);
        check("t3_blinks", blinks[1], 3);
        check("t3_ovfs", ovfs[1], 2);
        check("t3_blinks_d0", blinks[0], 5);

        clr();
        step(1'b1);
        drain(6);
        step(1'b1);
        drain(40);
        check("t4a_blinks", blinks[0], 2);

        clr();
        step(1'b1);
        drain(7);
        step(1'b1);
        drain(40);
        check("t4b_blinks", blinks[0], 2);

        clr();
        repeat (4) step(1'b1);
        trigger = 1'b0;
        check("t5_pend3", int'(pend0), 3);
        check("t5_led_on", int'(led_w[0]), 1);
        do_reset();
        clr();
        step(1'b1);
        drain(20);
        check("t5_blinks", blinks[0], 1);

        clr();
        repeat (4) step(1'b1);
        drain(20);
        check("t6_blinks", blinks[2], 4);
        check("t6_ovfs", ovfs[2], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
